// File: rtl/dac_seg_pkg.sv
// Shared constants, state type and thermometer helper for the segmented DAC encoder.
// The 12-bit code splits into 7 binary LSBs and a 5-bit MSB count (0..17).
package dac_seg_pkg;

  localparam int BIN_W   = 7;
  localparam int THERM_W = 17;
  localparam int CODE_W  = 12;
  localparam int MSB_W   = CODE_W - BIN_W;

  localparam logic [CODE_W-1:0] CODE_MAX = 12'd2303;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_SLEEP = 2'd3
  } state_e;

  // Element i is lit when i < m; m of 17 lights every element.
  function automatic logic [THERM_W-1:0] bin2therm(input logic [MSB_W-1:0] m);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_W; i++) begin
      t[i] = (m > MSB_W'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/dac_seg_seq.sv
// Power sequencer for the driver: OFF -> WAKE -> RUN -> SLEEP -> OFF with timed
// WAKE/SLEEP windows. Produces pdb, busy, code_ready and the zero-code force.
module dac_seg_seq
  import dac_seg_pkg::*;
#(
  parameter int WAKE_CYCLES  = 16,
  parameter int SLEEP_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_pdb,
  output logic o_busy,
  output logic o_code_ready,
  output logic o_force_zero
);

  localparam int CNT_MAX = (WAKE_CYCLES > SLEEP_CYCLES) ? WAKE_CYCLES : SLEEP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLEEP_LOAD = CNT_W'(SLEEP_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  // A drop of enable always passes through SLEEP, even mid-WAKE, so the driver
  // sees a full quiet window before pdb falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (i_enable) begin
            r_state <= ST_WAKE;
            r_cnt   <= WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (!i_enable) begin
            r_state <= ST_SLEEP;
            r_cnt   <= SLEEP_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            r_state <= ST_SLEEP;
            r_cnt   <= SLEEP_LOAD;
          end
        end
        ST_SLEEP: begin
          if (r_cnt == '0) begin
            r_state <= ST_OFF;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pdb        = (r_state != ST_OFF);
  assign o_busy       = (r_state == ST_WAKE) || (r_state == ST_SLEEP);
  assign o_code_ready = (r_state == ST_RUN) && i_enable;
  // Anything other than an enabled RUN cycle drives the outputs to zero-code.
  assign o_force_zero = !o_code_ready;

endmodule

// File: rtl/dac_seg_encoder.sv
// Segmented DAC front end: saturates the accepted code, splits it into binary
// LSBs and thermometer MSBs, and registers true and complement words together.
module dac_seg_encoder
  import dac_seg_pkg::*;
#(
  parameter int WAKE_CYCLES  = 16,
  parameter int SLEEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [CODE_W-1:0]  code,
  input  logic               code_valid,
  output logic               code_ready,
  output logic               sat,
  output logic               pdb,
  output logic [BIN_W-1:0]   datain,
  output logic [BIN_W-1:0]   datainb,
  output logic [THERM_W-1:0] datatherm,
  output logic [THERM_W-1:0] datathermb,
  output logic               busy
);

  logic               w_code_ready;
  logic               w_force_zero;
  logic               w_accept;
  logic               w_over;
  logic [CODE_W-1:0]  w_code_sat;
  logic [BIN_W-1:0]   w_bin;
  logic [THERM_W-1:0] w_therm;

  logic [BIN_W-1:0]   r_datain;
  logic [BIN_W-1:0]   r_datainb;
  logic [THERM_W-1:0] r_datatherm;
  logic [THERM_W-1:0] r_datathermb;
  logic               r_sat;

  dac_seg_seq #(
    .WAKE_CYCLES  (WAKE_CYCLES),
    .SLEEP_CYCLES (SLEEP_CYCLES)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (enable),
    .o_pdb        (pdb),
    .o_busy       (busy),
    .o_code_ready (w_code_ready),
    .o_force_zero (w_force_zero)
  );

  assign w_accept   = code_valid && w_code_ready;
  assign w_over     = (code > CODE_MAX);
  assign w_code_sat = w_over ? CODE_MAX : code;
  assign w_bin      = w_code_sat[BIN_W-1:0];
  assign w_therm    = bin2therm(w_code_sat[CODE_W-1:BIN_W]);

  // Output register stage: complements have their own flops so each pair flips
  // on the same edge and is never seen non-complementary downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_datain     <= '0;
      r_datainb    <= '1;
      r_datatherm  <= '0;
      r_datathermb <= '1;
      r_sat        <= 1'b0;
    end else if (w_force_zero) begin
      r_datain     <= '0;
      r_datainb    <= '1;
      r_datatherm  <= '0;
      r_datathermb <= '1;
      r_sat        <= 1'b0;
    end else if (w_accept) begin
      r_datain     <= w_bin;
      r_datainb    <= ~w_bin;
      r_datatherm  <= w_therm;
      r_datathermb <= ~w_therm;
      r_sat        <= w_over;
    end else begin
      r_sat        <= 1'b0;
    end
  end

  assign code_ready = w_code_ready;
  assign sat        = r_sat;
  assign datain     = r_datain;
  assign datainb    = r_datainb;
  assign datatherm  = r_datatherm;
  assign datathermb = r_datathermb;

endmodule

// File: doc/dac_seg_encoder.md
Name: dac_seg_encoder

Overview:
- Digital front end feeding driver_cell: converts a 12-bit unsigned DAC code into the segmented control words driver_cell consumes (7-bit binary LSBs, 17-element thermometer MSBs, each with an exact complement).
- Owns the driver's pdb power sequencing.
- Accepts codes over a valid/ready handshake and presents registered, glitch-free control words.

Parameters:
- WAKE_CYCLES, 16, cycles pdb is high with outputs forced to zero-code before codes are accepted.
- SLEEP_CYCLES, 8, cycles outputs are held at zero-code before pdb is dropped.
- CODE_MAX, 2303, maximum representable code (17*128+127); larger inputs saturate.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level request: 1 = power driver up, 0 = power down
- code  in  12  unsigned DAC code
- code_valid  in  1  code is presented
- code_ready  out  1  block accepts code this cycle
- sat  out  1  pulse: last accepted code exceeded CODE_MAX
- pdb  out  1  driver power-down bar
- datain  out  7  binary LSB control
- datainb  out  7  bitwise complement of datain
- datatherm  out  17  thermometer MSB control
- datathermb  out  17  bitwise complement of datatherm
- busy  out  1  FSM is in WAKE or SLEEP

Behaviour:
- Reset (async, rst_n=0) values:
  - state=OFF, pdb=0, datain=0, datainb=7'h7F, datatherm=0, datathermb=17'h1FFFF.
  - code_ready=0, sat=0, busy=0.
- Zero-code means datain=0 and datatherm=0 with the complements all ones. Complement outputs are driven from their own flops, loaded on the same edge as the true outputs, so a true/complement pair is never non-complementary.
- FSM states OFF, WAKE, RUN, SLEEP:
  - OFF: pdb=0, zero-code. enable=1 -> WAKE, load counter with WAKE_CYCLES-1.
  - WAKE: pdb=1, zero-code. Counter decrements each cycle; on 0 -> RUN. If enable=0 during WAKE -> SLEEP.
  - RUN: pdb=1, code_ready=1. enable=0 -> SLEEP with counter=SLEEP_CYCLES-1, and the outputs load zero-code on that same edge.
  - SLEEP: pdb=1, zero-code. Counter reaches 0 -> OFF (pdb=0 the following cycle). If enable=1 during SLEEP, the sequence still completes to OFF and then re-enters WAKE on the next cycle.
- code_ready=1 only in RUN while enable=1.
- Accept when code_valid && code_ready.
- Latency: outputs update on the edge after acceptance (1 cycle). Without a new accept, outputs hold their last value.
- Encoding of an accepted code:
  - c = min(code, CODE_MAX).
  - datain = c[6:0].
  - m = c[11:7], range 0..17.
  - datatherm[i] = (i < m) for i = 0..16.
  - sat=1 for exactly 1 cycle when code > CODE_MAX was accepted, otherwise 0.
- Boundaries:
  - code=2303 -> datatherm all ones, datain=7'h7F.
  - code=2304 and above -> same outputs, sat=1.
  - code_valid asserted while not ready -> ignored, no effect.
  - Reset mid-RUN -> immediate reset values, pdb drops asynchronously.

Decomposition:
- Package dac_seg_pkg holds:
  - the state enum (OFF, WAKE, RUN, SLEEP);
  - the constants BIN_W=7, THERM_W=17, CODE_W=12, CODE_MAX;
  - a function bin2therm(m) returning 17 bits.
- One sub-module, dac_seg_seq: FSM plus counter, producing pdb, busy, code_ready and a force-zero signal.
- The top level holds the encode and output registers.

Test Plan:
- Reset release with enable=0 -> pdb=0, datain=0, datainb=7'h7F, datatherm=0, datathermb=17'h1FFFF, code_ready=0.
- enable=1 at cycle 0 -> pdb=1 at cycle 1, busy=1 for 16 cycles, code_ready=1 from cycle 17; all data outputs stay zero-code throughout.
- In RUN accept code=12'h2CC (716) -> next cycle datain=7'h4C, datatherm=17'h0001F, datainb=7'h33, datathermb=17'h1FFE0, sat=0.
- Accept code=12'hFFF -> datain=7'h7F, datatherm=17'h1FFFF, complements all zero, sat=1 for exactly 1 cycle.
- enable=0 in RUN -> zero-code on the next edge, pdb stays 1 for 8 cycles then drops to 0, code_ready=0 throughout; code_valid pulses during SLEEP cause no output change.
- rst_n asserted mid-RUN holding code 716 -> all outputs return to their reset values immediately; after release with enable=1 the WAKE sequence restarts from cycle 0.
